// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : State, opcode/funct and control-field encodings for mc_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] EOP_SIGN = 2'b00;
    localparam logic [1:0] EOP_ZERO = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_BR   = 2'b11;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_OR  = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_RA  = 2'b10;

    // One-hot instruction class; all-zero means undecodable.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
    } ins_t;

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module : mc_decode
// Brief  : Combinational op/funct decoder to one-hot instruction class.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ins_t       ins,
    output logic       illegal
);

    always_comb begin
        ins = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: ins.addu = 1'b1;
                    FN_SUBU: ins.subu = 1'b1;
                    FN_JR:   ins.jr   = 1'b1;
                    default: ins      = '0;
                endcase
            end
            OP_ORI:  ins.ori = 1'b1;
            OP_LUI:  ins.lui = 1'b1;
            OP_LW:   ins.lw  = 1'b1;
            OP_SW:   ins.sw  = 1'b1;
            OP_BEQ:  ins.beq = 1'b1;
            OP_J:    ins.j   = 1'b1;
            OP_JAL:  ins.jal = 1'b1;
            default: ins     = '0;
        endcase
        illegal = (ins == '0);
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module : mc_ctrl
// Brief  : Multi-cycle IF/ID/EX/MEM/WB control FSM for the MIPS-subset datapath.
//          Optional cycle counter output enabled by macro MC_CTRL_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             ir_we,
    output logic [1:0]       eop,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             mem_re,
    output logic             mem_we,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       w_retire;
    logic       w_dec_illegal;
    logic       w_fetch;
    ins_t       w_ins;

    mc_decode u_decode (
        .op      (op),
        .funct   (funct),
        .ins     (w_ins),
        .illegal (w_dec_illegal)
    );

    // Gating fetch with rst_n keeps every strobe low while reset is held.
    assign w_fetch = run & rst_n;

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        pc_we       = 1'b0;
        npc_sel     = NPC_PC4;
        ir_we       = 1'b0;
        eop         = EOP_SIGN;
        alu_op      = ALUOP_ADD;
        alu_src     = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = RDST_RT;
        wd_sel      = WD_ALU;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_IF: begin
                if (w_fetch) begin
                    ir_we       = 1'b1;
                    pc_we       = 1'b1;
                    w_state_nxt = S_ID;
                end
            end
            S_ID: begin
                if (w_ins.j || w_ins.jal) begin
                    pc_we       = 1'b1;
                    npc_sel     = NPC_JMP;
                    w_state_nxt = S_IF;
                    w_retire    = 1'b1;
                    if (w_ins.jal) begin
                        reg_we  = 1'b1;
                        reg_dst = RDST_RA;
                        wd_sel  = WD_PC4;
                    end
                end else if (w_ins.jr) begin
                    pc_we       = 1'b1;
                    npc_sel     = NPC_JR;
                    w_state_nxt = S_IF;
                    w_retire    = 1'b1;
                end else if (w_dec_illegal) begin
                    illegal     = 1'b1;
                    w_state_nxt = S_IF;
                end else begin
                    w_state_nxt = S_EX;
                end
            end
            S_EX: begin
                if (w_ins.addu || w_ins.subu) begin
                    alu_op      = w_ins.subu ? ALUOP_SUB : ALUOP_ADD;
                    w_state_nxt = S_WB;
                end else if (w_ins.ori || w_ins.lui) begin
                    eop         = w_ins.lui ? EOP_LUI : EOP_ZERO;
                    alu_op      = ALUOP_OR;
                    alu_src     = 1'b1;
                    w_state_nxt = S_WB;
                end else if (w_ins.lw || w_ins.sw) begin
                    alu_src     = 1'b1;
                    w_state_nxt = S_MEM;
                end else begin
                    eop         = EOP_BR;
                    alu_op      = ALUOP_SUB;
                    pc_we       = zero;
                    npc_sel     = NPC_BR;
                    w_state_nxt = S_IF;
                    w_retire    = 1'b1;
                end
            end
            S_MEM: begin
                alu_src = 1'b1;
                mem_re  = w_ins.lw;
                mem_we  = w_ins.sw;
                if (mem_ready) begin
                    w_state_nxt = w_ins.sw ? S_IF : S_WB;
                    w_retire    = w_ins.sw;
                end
            end
            S_WB: begin
                reg_we      = 1'b1;
                reg_dst     = (w_ins.addu || w_ins.subu) ? RDST_RD : RDST_RT;
                wd_sel      = w_ins.lw ? WD_DM : WD_ALU;
                w_state_nxt = S_IF;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IF;
            retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else if (r_state != S_IF || run) begin
            cycles <= cycles + CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module : tb_mc_ctrl
// Brief  : Directed self-checking bench for mc_ctrl (MC_CTRL_PERF_EN optional).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mc_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n, run, zero, mem_ready;
    logic [5:0]       op, funct;
    logic             pc_we, ir_we, alu_src, reg_we, mem_re, mem_we, illegal;
    logic [1:0]       npc_sel, eop, alu_op, reg_dst, wd_sel;
    logic [CNT_W-1:0] retired;
`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .npc_sel   (npc_sel),
        .ir_we     (ir_we),
        .eop       (eop),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .illegal   (illegal),
        .retired   (retired)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycles    (cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; op = 6'h00; funct = 6'h00;
        zero = 1'b0; mem_ready = 1'b0;
        #3;
        check("rst_retired", retired, 0);
        check("rst_ir_we", ir_we, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_npc_sel", npc_sel, 0);
`ifdef MC_CTRL_PERF_EN
        check("rst_cycles", cycles, 0);
`endif
        tick(); tick();
        rst_n = 1'b1; #1;
        check("idle_ir_we", ir_we, 0);

        // addu: IF, ID, EX, WB
        funct = 6'h21; run = 1'b1; #1;
        check("addu_if_ir_we", ir_we, 1);
        check("addu_if_pc_we", pc_we, 1);
        tick();
        check("addu_id_reg_we", reg_we, 0);
        check("addu_id_pc_we", pc_we, 0);
        tick();
        check("addu_ex_alu_op", alu_op, 0);
        check("addu_ex_alu_src", alu_src, 0);
        check("addu_ex_reg_we", reg_we, 0);
        tick();
        check("addu_wb_reg_we", reg_we, 1);
        check("addu_wb_reg_dst", reg_dst, 1);
        check("addu_wb_wd_sel", wd_sel, 0);
        tick();
        check("addu_retired", retired, 1);
`ifdef MC_CTRL_PERF_EN
        check("addu_cycles", cycles, 4);
`endif

        // ori then lui
        op = 6'h0d;
        tick(); tick();
        check("ori_ex_eop", eop, 1);
        check("ori_ex_alu_op", alu_op, 2);
        check("ori_ex_alu_src", alu_src, 1);
        tick();
        check("ori_wb_reg_we", reg_we, 1);
        check("ori_wb_reg_dst", reg_dst, 0);
        check("ori_wb_eop", eop, 0);
        tick();
        op = 6'h0f;
        tick(); tick();
        check("lui_ex_eop", eop, 2);
        check("lui_ex_alu_src", alu_src, 1);
        tick(); tick();
        check("lui_retired", retired, 3);

        // lw with three wait cycles
        op = 6'h23;
        tick(); tick();
        check("lw_ex_eop", eop, 0);
        check("lw_ex_alu_src", alu_src, 1);
        check("lw_ex_mem_re", mem_re, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_mem_wait_re", mem_re, 1);
        end
        tick();
        mem_ready = 1'b1; #1;
        check("lw_mem_last_re", mem_re, 1);
        tick();
        mem_ready = 1'b0;
        check("lw_wb_reg_we", reg_we, 1);
        check("lw_wb_wd_sel", wd_sel, 1);
        check("lw_wb_mem_re", mem_re, 0);
        tick();
        check("lw_retired", retired, 4);

        // beq taken, then not taken
        op = 6'h04; zero = 1'b1;
        tick(); tick();
        check("beq1_ex_eop", eop, 3);
        check("beq1_ex_alu_op", alu_op, 1);
        check("beq1_ex_pc_we", pc_we, 1);
        check("beq1_ex_npc_sel", npc_sel, 1);
        tick();
        check("beq1_retired", retired, 5);
        zero = 1'b0;
        tick(); tick();
        check("beq0_ex_eop", eop, 3);
        check("beq0_ex_pc_we", pc_we, 0);
        tick();
        check("beq0_retired", retired, 6);

        // jal
        op = 6'h03;
        tick();
        check("jal_id_pc_we", pc_we, 1);
        check("jal_id_npc_sel", npc_sel, 2);
        check("jal_id_reg_we", reg_we, 1);
        check("jal_id_reg_dst", reg_dst, 2);
        check("jal_id_wd_sel", wd_sel, 2);
        tick();
        check("jal_retired", retired, 7);

        // undecodable opcode
        op = 6'h3f;
        tick();
        check("ill_id_illegal", illegal, 1);
        check("ill_id_pc_we", pc_we, 0);
        tick();
        check("ill_if_illegal", illegal, 0);
        check("ill_retired", retired, 7);

        // jr
        op = 6'h00; funct = 6'h08;
        tick();
        check("jr_id_pc_we", pc_we, 1);
        check("jr_id_npc_sel", npc_sel, 3);
        tick();
        check("jr_retired", retired, 8);

        // sw aborted by async reset while waiting in MEM
        op = 6'h2b; funct = 6'h00;
        tick(); tick(); tick();
        check("sw_mem_we_a", mem_we, 1);
        tick();
        check("sw_mem_we_b", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_we", mem_we, 0);
        check("abort_retired", retired, 0);
        check("abort_ir_we", ir_we, 0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("hold_ir_we", ir_we, 0);
        check("hold_pc_we", pc_we, 0);
        check("hold_retired", retired, 0);
        run = 1'b1; #1;
        check("resume_ir_we", ir_we, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
